bc_turn_sched: RTL and testbench
================================

Name: bc_turn_sched

Overview:
Two-player round scheduler for the Bulls-and-Cows game on the board.
- Players alternate between setter (enters the secret) and guesser.
- Shares one external A/B scoring engine through a req/ack handshake.
- Counts tries, rounds and per-player wins.
- Drives state, role and progress outputs consumed by the HEX/LED display logic.

Parameters:
MAX_TRIES, 18, guesses allowed per round (1..31); also the width of try_bar
ROUNDS, 4, rounds per match (even, 2..15)
ACK_TIMEOUT, 15, clk18 cycles SCORE waits for sc_ack before aborting the guess
TURN_TICKS, 540, clk18 cycles allowed per guess (only with BC_TURN_TIMEOUT_EN)

Ports:
clk18  in  1  system tick, ~18 Hz divided clock
rst  in  1  asynchronous, active-low reset
key_n  in  1  debounced push button, active-low level
sw_code  in  16  four 4-bit digits, [15:12] most significant
sc_req  out  1  scoring request, held until acknowledged
sc_secret  out  16  latched secret, stable while sc_req=1
sc_guess  out  16  latched guess, stable while sc_req=1
sc_ack  in  1  one-cycle scoring-done strobe
sc_a  in  3  A count, valid with sc_ack
sc_b  in  3  B count, valid with sc_ack
state  out  3  IDLE=0, SET=1, HIDE=2, GUESS=3, SCORE=4, RESULT=5, OVER=6
setter  out  1  player currently setting the secret (guesser = ~setter)
last_a  out  3  A count of the last scored guess
last_b  out  3  B count of the last scored guess
try_bar  out  MAX_TRIES  thermometer of tries used, LSB first
round  out  4  rounds completed
wins0  out  4  player 0 wins
wins1  out  4  player 1 wins
win  out  1  last round ended with 4A
err  out  1  scoring timeout occurred this round (sticky until round end)
tmo  out  1  turn timeout occurred (0 when feature absent)

Behaviour:
- Reset (rst=0, async): state=IDLE; setter=0; sc_req=0; sc_secret=0; sc_guess=0; last_a=0; last_b=0; try_bar=0; round=0; wins0=0; wins1=0; win=0; err=0; tmo=0; internal key history=1 (released).
- press = key history 1 and key_n 0 on this edge. One-cycle internal pulse. Holding the key generates no further presses.
- valid = all four digits ≤ 9 and pairwise distinct.
- clear = sw_code==0.
- IDLE: press -> SET.
- SET: press & valid -> latch sc_secret=sw_code, go HIDE. Press & !valid -> ignored.
- HIDE: press & clear -> GUESS. Any other press is ignored. This forces the setter to wipe the switches.
- GUESS: press & valid -> latch sc_guess, sc_req=1 next cycle, enter SCORE. Press & !valid -> ignored, try not consumed.
- SCORE:
  - sc_req stays 1 and sc_secret/sc_guess stay frozen until sc_ack. sc_ack outside SCORE is ignored.
  - On the ack cycle: sc_req=0, last_a/last_b captured, try_bar shifts in a 1.
  - If sc_a==4 -> RESULT with win=1.
  - Else if this was try MAX_TRIES -> RESULT with win=0.
  - Else -> GUESS.
  - Ack on the same cycle as the timeout expiry counts as the ack.
  - Timeout: ACK_TIMEOUT cycles without ack -> sc_req=0, err=1, back to GUESS, try not consumed.
- RESULT:
  - On entry (one cycle): if win, guesser's wins+1; else setter's wins+1. round+1. Win counters saturate at 15.
  - Then wait for press & clear: toggle setter; clear try_bar, err, tmo, win, last_a, last_b.
  - Go to OVER if round==ROUNDS, else SET.
- OVER: all outputs hold. Press -> IDLE with round=0, wins0=0, wins1=0, setter=0.
- Reset mid-SCORE drops sc_req immediately. There is no state other than reset values.
- Unused state encodings (7) go to IDLE next cycle.
- All outputs are registered; latency from press to state change is 1 clk18.

Optional Feature:
BC_TURN_TIMEOUT_EN
- Defined: a turn counter runs in GUESS and restarts on every GUESS entry.
  - Reaching TURN_TICKS with no valid press forfeits the try: try_bar shifts, last_a=0, last_b=0, tmo=1.
  - The exhaustion rule applies: that try can end the round as a loss.
  - A valid press on the expiry cycle wins over the timeout.
- Undefined: no turn counter is built; tmo is tied to 0.

Test Plan:
1. Reset, press, SW=0x1234, press, SW=0, press, guess 0x1234, ack with a=4 b=0 -> RESULT, win=1, wins1=1, round=1, try_bar=0x00001.
2. Guess 0x1244 in SET and in GUESS -> ignored, state unchanged, try_bar unchanged.
3. Secret 0x5678, 18 guesses of 0x1234 each acked a=0 b=0 -> RESULT win=0, wins0=1, try_bar=0x3FFFF.
4. In SCORE hold sc_ack=0 for 15 cycles -> sc_req falls, err=1, state=GUESS, try_bar unchanged; sc_secret and sc_guess stable throughout.
5. Play 4 rounds -> setter toggles 0,1,0,1, OVER reached with round=4; press -> IDLE, counters 0.
6. BC_TURN_TIMEOUT_EN defined, TURN_TICKS=5: idle in GUESS 5 cycles -> tmo=1, try_bar=0x00001, state stays GUESS.

Source files
------------

// File: rtl/bc_turn_sched.sv
// bc_turn_sched: two-player Bulls-and-Cows round scheduler sharing one external A/B scoring engine.
// Optional per-guess turn timeout is built only when BC_TURN_TIMEOUT_EN is defined.
module bc_turn_sched #(
    parameter int MAX_TRIES   = 18,
    parameter int ROUNDS      = 4,
    parameter int ACK_TIMEOUT = 15,
    parameter int TURN_TICKS  = 540
) (
    input  logic                 clk18,
    input  logic                 rst,
    input  logic                 key_n,
    input  logic [15:0]          sw_code,
    output logic                 sc_req,
    output logic [15:0]          sc_secret,
    output logic [15:0]          sc_guess,
    input  logic                 sc_ack,
    input  logic [2:0]           sc_a,
    input  logic [2:0]           sc_b,
    output logic [2:0]           state,
    output logic                 setter,
    output logic [2:0]           last_a,
    output logic [2:0]           last_b,
    output logic [MAX_TRIES-1:0] try_bar,
    output logic [3:0]           round,
    output logic [3:0]           wins0,
    output logic [3:0]           wins1,
    output logic                 win,
    output logic                 err,
    output logic                 tmo
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SET    = 3'd1;
    localparam logic [2:0] S_HIDE   = 3'd2;
    localparam logic [2:0] S_GUESS  = 3'd3;
    localparam logic [2:0] S_SCORE  = 3'd4;
    localparam logic [2:0] S_RESULT = 3'd5;
    localparam logic [2:0] S_OVER   = 3'd6;

    localparam int               ACK_W      = $clog2(ACK_TIMEOUT + 1);
    localparam logic [ACK_W-1:0] ACK_LAST   = ACK_W'(ACK_TIMEOUT - 1);
    localparam logic [4:0]       TRY_LAST   = 5'(MAX_TRIES - 1);
    localparam logic [3:0]       ROUND_LAST = 4'(ROUNDS);

    if (MAX_TRIES < 1 || MAX_TRIES > 31 || ROUNDS < 2 || ROUNDS > 15 || (ROUNDS % 2) != 0 ||
        ACK_TIMEOUT < 1 || TURN_TICKS < 1) begin : g_param_check
        $error("bc_turn_sched: parameter out of range");
    end

    function automatic logic code_valid(input logic [15:0] code);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (code[4*i +: 4] > 4'd9) ok = 1'b0;
            for (int j = i + 1; j < 4; j++)
                if (code[4*i +: 4] == code[4*j +: 4]) ok = 1'b0;
        end
        return ok;
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    logic [2:0]       state_next;
    logic             key_hist, press, valid, clear;
    logic [ACK_W-1:0] ack_cnt;
    logic             ack_expire;
    logic [4:0]       tries;
    logic             last_try;
    logic             turn_expire;
    logic             latch_secret, latch_guess, score_done, score_abort, forfeit;
    logic             round_end, end_win, round_clear, match_clear;

    assign press      = key_hist & ~key_n;
    assign valid      = code_valid(sw_code);
    assign clear      = (sw_code == 16'h0000);
    assign ack_expire = (ack_cnt == ACK_LAST);
    assign last_try   = (tries == TRY_LAST);

    always_ff @(posedge clk18 or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (press) state_next = S_SET;
            S_SET:    if (latch_secret) state_next = S_HIDE;
            S_HIDE:   if (press && clear) state_next = S_GUESS;
            S_GUESS: begin
                if (latch_guess)    state_next = S_SCORE;
                else if (round_end) state_next = S_RESULT;
            end
            S_SCORE: begin
                if (round_end)                      state_next = S_RESULT;
                else if (score_done || score_abort) state_next = S_GUESS;
            end
            S_RESULT: if (round_clear) state_next = (round == ROUND_LAST) ? S_OVER : S_SET;
            S_OVER:   if (press) state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // A valid guess on the turn-expiry cycle takes precedence over the forfeit.
    always_comb begin
        latch_secret = 1'b0;
        latch_guess  = 1'b0;
        score_done   = 1'b0;
        score_abort  = 1'b0;
        forfeit      = 1'b0;
        round_end    = 1'b0;
        end_win      = 1'b0;
        round_clear  = 1'b0;
        match_clear  = 1'b0;
        case (state)
            S_SET:   latch_secret = press & valid;
            S_GUESS: begin
                latch_guess = press & valid;
                forfeit     = turn_expire & ~latch_guess;
                round_end   = forfeit & last_try;
            end
            S_SCORE: begin
                score_done  = sc_ack;
                score_abort = ~sc_ack & ack_expire;
                end_win     = sc_ack & (sc_a == 3'd4);
                round_end   = sc_ack & ((sc_a == 3'd4) | last_try);
            end
            S_RESULT: round_clear = press & clear;
            S_OVER:   match_clear = press;
            default:  ;
        endcase
    end

    always_ff @(posedge clk18 or negedge rst) begin
        if (!rst) begin
            key_hist  <= 1'b1;
            ack_cnt   <= '0;
            tries     <= '0;
            sc_req    <= 1'b0;
            sc_secret <= '0;
            sc_guess  <= '0;
            setter    <= 1'b0;
            last_a    <= '0;
            last_b    <= '0;
            try_bar   <= '0;
            round     <= '0;
            wins0     <= '0;
            wins1     <= '0;
            win       <= 1'b0;
            err       <= 1'b0;
        end else begin
            key_hist <= key_n;
            if (state == S_SCORE && !score_done && !score_abort) ack_cnt <= ack_cnt + 1'b1;
            else                                                 ack_cnt <= '0;
            if (latch_secret) sc_secret <= sw_code;
            if (latch_guess) begin
                sc_guess <= sw_code;
                sc_req   <= 1'b1;
            end else if (score_done || score_abort) begin
                sc_req <= 1'b0;
            end
            if (score_done || forfeit) begin
                try_bar <= (try_bar << 1) | MAX_TRIES'(1);
                tries   <= tries + 5'd1;
                last_a  <= score_done ? sc_a : 3'd0;
                last_b  <= score_done ? sc_b : 3'd0;
            end
            if (score_abort) err <= 1'b1;
            // Winner is the guesser (~setter) on a 4A, otherwise the setter.
            if (round_end) begin
                win   <= end_win;
                round <= round + 4'd1;
                if (end_win ^ setter) wins1 <= sat_inc(wins1);
                else                  wins0 <= sat_inc(wins0);
            end
            if (round_clear) begin
                setter  <= ~setter;
                try_bar <= '0;
                tries   <= '0;
                err     <= 1'b0;
                win     <= 1'b0;
                last_a  <= '0;
                last_b  <= '0;
            end
            if (match_clear) begin
                round  <= '0;
                wins0  <= '0;
                wins1  <= '0;
                setter <= 1'b0;
            end
        end
    end

`ifdef BC_TURN_TIMEOUT_EN
    localparam int                TURN_W    = $clog2(TURN_TICKS + 1);
    localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'(TURN_TICKS - 1);

    logic [TURN_W-1:0] turn_cnt;

    assign turn_expire = (state == S_GUESS) && (turn_cnt == TURN_LAST);

    always_ff @(posedge clk18 or negedge rst) begin
        if (!rst) begin
            turn_cnt <= '0;
            tmo      <= 1'b0;
        end else begin
            if (state != S_GUESS || latch_guess || forfeit) turn_cnt <= '0;
            else                                            turn_cnt <= turn_cnt + 1'b1;
            if (forfeit)          tmo <= 1'b1;
            else if (round_clear) tmo <= 1'b0;
        end
    end
`else
    assign turn_expire = 1'b0;
    assign tmo         = 1'b0;
`endif

endmodule

// File: tb/tb_bc_turn_sched.sv
// Bench for bc_turn_sched: vector table, hand-written corner sequences and randomized play
// checked every cycle against a behavioural model of the game rules.
module tb_bc_turn_sched;

    localparam int MT = 18;
    localparam int RN = 4;
    localparam int AT = 15;
`ifdef BC_TURN_TIMEOUT_EN
    localparam int TT = 5;
`else
    localparam int TT = 540;
`endif

    logic          clk18 = 1'b0;
    logic          rst = 1'b0;
    logic          key_n = 1'b1;
    logic [15:0]   sw_code = '0;
    logic          sc_ack = 1'b0;
    logic [2:0]    sc_a = '0, sc_b = '0;
    logic          sc_req, setter, win, err, tmo;
    logic [15:0]   sc_secret, sc_guess;
    logic [2:0]    state, last_a, last_b;
    logic [MT-1:0] try_bar;
    logic [3:0]    round, wins0, wins1;

    bc_turn_sched #(.MAX_TRIES(MT), .ROUNDS(RN), .ACK_TIMEOUT(AT), .TURN_TICKS(TT)) dut (
        .clk18(clk18), .rst(rst), .key_n(key_n), .sw_code(sw_code),
        .sc_req(sc_req), .sc_secret(sc_secret), .sc_guess(sc_guess),
        .sc_ack(sc_ack), .sc_a(sc_a), .sc_b(sc_b),
        .state(state), .setter(setter), .last_a(last_a), .last_b(last_b),
        .try_bar(try_bar), .round(round), .wins0(wins0), .wins1(wins1),
        .win(win), .err(err), .tmo(tmo)
    );

    always #5 clk18 = ~clk18;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    int          m_state, m_tries, m_wait, m_turn, m_round;
    logic        m_key, m_setter, m_req, m_win, m_err, m_tmo;
    logic [15:0] m_secret, m_guess;
    logic [2:0]  m_a, m_b;
    logic [3:0]  m_w0, m_w1;

    function automatic bit is_valid(input logic [15:0] c);
        bit seen[10];
        for (int i = 0; i < 4; i++) begin
            int d = int'(c[4*i +: 4]);
            if (d > 9 || seen[d]) return 0;
            seen[d] = 1;
        end
        return 1;
    endfunction

    function automatic logic [MT-1:0] bar(input int n);
        logic [MT-1:0] r = '0;
        for (int i = 0; i < n; i++) r[i] = 1'b1;
        return r;
    endfunction

    task automatic model_reset();
        m_state = 0; m_tries = 0; m_wait = 0; m_turn = 0; m_round = 0;
        m_key = 1; m_setter = 0; m_req = 0; m_win = 0; m_err = 0; m_tmo = 0;
        m_secret = 0; m_guess = 0; m_a = 0; m_b = 0; m_w0 = 0; m_w1 = 0;
    endtask

    task automatic end_round(input bit w);
        bit winner;
        winner = w ? !m_setter : m_setter;
        m_win = w;
        if (winner) begin if (m_w1 != 4'hF) m_w1 = m_w1 + 1; end
        else        begin if (m_w0 != 4'hF) m_w0 = m_w0 + 1; end
        m_round = m_round + 1;
        m_state = 5;
    endtask

    task automatic model_step(input logic kn, input logic [15:0] sw, input logic ack,
                              input logic [2:0] a, input logic [2:0] b);
        bit press;
        press = m_key && !kn;
        m_key = kn;
        case (m_state)
            0: if (press) m_state = 1;
            1: if (press && is_valid(sw)) begin m_secret = sw; m_state = 2; end
            2: if (press && sw == 0) m_state = 3;
            3: begin
                if (press && is_valid(sw)) begin
                    m_guess = sw; m_req = 1; m_wait = 0; m_state = 4;
                end
`ifdef BC_TURN_TIMEOUT_EN
                else begin
                    m_turn++;
                    if (m_turn == TT) begin
                        m_turn = 0; m_tries++; m_a = 0; m_b = 0; m_tmo = 1;
                        if (m_tries == MT) end_round(0);
                    end
                end
`endif
            end
            4: begin
                if (ack) begin
                    m_req = 0; m_a = a; m_b = b; m_tries++;
                    if (a == 3'd4)         end_round(1);
                    else if (m_tries == MT) end_round(0);
                    else                    m_state = 3;
                end else begin
                    m_wait++;
                    if (m_wait == AT) begin m_req = 0; m_err = 1; m_state = 3; end
                end
            end
            5: if (press && sw == 0) begin
                m_setter = !m_setter; m_tries = 0; m_err = 0; m_tmo = 0; m_win = 0;
                m_a = 0; m_b = 0;
                m_state = (m_round == RN) ? 6 : 1;
            end
            6: if (press) begin m_round = 0; m_w0 = 0; m_w1 = 0; m_setter = 0; m_state = 0; end
            default: m_state = 0;
        endcase
        if (m_state != 3) m_turn = 0;
    endtask

    task automatic chk_model(input string name);
        chk(name,
            96'({state, setter, sc_req, sc_secret, sc_guess, last_a, last_b, try_bar,
                 round, wins0, wins1, win, err, tmo}),
            96'({3'(m_state), m_setter, m_req, m_secret, m_guess, m_a, m_b, bar(m_tries),
                 4'(m_round), m_w0, m_w1, m_win, m_err, m_tmo}));
    endtask

    // One clock: inputs applied at edge+1, model advanced with the same inputs, outputs sampled at edge+1.
    task automatic step(input logic kn, input logic [15:0] sw, input logic ack = 1'b0,
                        input logic [2:0] a = 3'd0, input logic [2:0] b = 3'd0);
        key_n = kn; sw_code = sw; sc_ack = ack; sc_a = a; sc_b = b;
        @(posedge clk18);
        model_step(kn, sw, ack, a, b);
        #1;
        chk_model("model");
    endtask

    task automatic press(input logic [15:0] sw);
        step(1'b0, sw);
        step(1'b1, sw);
    endtask

    task automatic start_round(input logic [15:0] secret);
        press(secret);
        press(16'h0000);
    endtask

    task automatic guess(input logic [15:0] code, input logic [2:0] a, input logic [2:0] b);
        press(code);
        step(1'b1, code, 1'b1, a, b);
    endtask

    // Asserts reset mid-cycle and checks it acts without waiting for a clock edge.
    task automatic do_reset();
        key_n = 1'b1; sw_code = '0; sc_ack = 1'b0; sc_a = '0; sc_b = '0;
        #2 rst = 1'b0;
        #1;
        chk("async_rst_req", 96'(sc_req), 96'(0));
        chk("async_rst_state", 96'(state), 96'(0));
        model_reset();
        @(posedge clk18);
        #1 rst = 1'b1;
    endtask

    function automatic logic [15:0] rand_valid();
        logic [15:0] c;
        do c = 16'($urandom); while (!is_valid(c));
        return c;
    endfunction

    typedef struct {
        logic        kn;
        logic [15:0] sw;
        logic        ack;
        logic [2:0]  a;
        logic [2:0]  st;
        logic        req;
        int          tries;
        logic        setter;
        logic        chk_score;
        logic [3:0]  w0, w1, rnd;
        logic        win;
    } vec_t;

    vec_t tbl[19];

    initial begin
        logic kn_cur;
        logic [15:0] sw_r;

        tbl[0]  = '{1'b0, 16'h0000, 1'b0, 3'd0, 3'd1, 1'b0, 0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0};
        tbl[1]  = '{1'b1, 16'h1234, 1'b0, 3'd0, 3'd1, 1'b0, 0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0};
        tbl[2]  = '{1'b0, 16'h1244, 1'b0, 3'd0, 3'd1, 1'b0, 0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0};
        tbl[3]  = '{1'b1, 16'h1234, 1'b0, 3'd0, 3'd1, 1'b0, 0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0};
        tbl[4]  = '{1'b0, 16'h1234, 1'b0, 3'd0, 3'd2, 1'b0, 0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0};
        tbl[5]  = '{1'b1, 16'h1234, 1'b0, 3'd0, 3'd2, 1'b0, 0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0};
        tbl[6]  = '{1'b0, 16'h1234, 1'b0, 3'd0, 3'd2, 1'b0, 0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0};
        tbl[7]  = '{1'b1, 16'h0000, 1'b0, 3'd0, 3'd2, 1'b0, 0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0};
        tbl[8]  = '{1'b0, 16'h0000, 1'b0, 3'd0, 3'd3, 1'b0, 0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0};
        tbl[9]  = '{1'b1, 16'h1244, 1'b0, 3'd0, 3'd3, 1'b0, 0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0};
        tbl[10] = '{1'b0, 16'h1244, 1'b0, 3'd0, 3'd3, 1'b0, 0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0};
        tbl[11] = '{1'b1, 16'h1234, 1'b0, 3'd0, 3'd3, 1'b0, 0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0};
        tbl[12] = '{1'b0, 16'h1234, 1'b0, 3'd0, 3'd4, 1'b1, 0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0};
        tbl[13] = '{1'b0, 16'h1234, 1'b0, 3'd0, 3'd4, 1'b1, 0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0};
        tbl[14] = '{1'b1, 16'h1234, 1'b1, 3'd4, 3'd5, 1'b0, 1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0};
        tbl[15] = '{1'b1, 16'h1234, 1'b0, 3'd0, 3'd5, 1'b0, 1, 1'b0, 1'b1, 4'd0, 4'd1, 4'd1, 1'b1};
        tbl[16] = '{1'b0, 16'h1234, 1'b0, 3'd0, 3'd5, 1'b0, 1, 1'b0, 1'b1, 4'd0, 4'd1, 4'd1, 1'b1};
        tbl[17] = '{1'b1, 16'h0000, 1'b0, 3'd0, 3'd5, 1'b0, 1, 1'b0, 1'b1, 4'd0, 4'd1, 4'd1, 1'b1};
        tbl[18] = '{1'b0, 16'h0000, 1'b0, 3'd0, 3'd1, 1'b0, 0, 1'b1, 1'b1, 4'd0, 4'd1, 4'd1, 1'b0};

        // Reset values
        model_reset();
        @(posedge clk18);
        #1;
        chk_model("reset_values");
        rst = 1'b1;

        // Basic round with a win, invalid codes ignored in SET, HIDE and GUESS
        foreach (tbl[i]) begin
            step(tbl[i].kn, tbl[i].sw, tbl[i].ack, tbl[i].a, 3'd0);
            chk($sformatf("vec%0d_ctl", i), 96'({state, sc_req, try_bar, setter}),
                96'({tbl[i].st, tbl[i].req, bar(tbl[i].tries), tbl[i].setter}));
            if (tbl[i].chk_score)
                chk($sformatf("vec%0d_score", i), 96'({wins0, wins1, round, win}),
                    96'({tbl[i].w0, tbl[i].w1, tbl[i].rnd, tbl[i].win}));
        end

        // Exhausting all tries is a loss credited to the setter
        do_reset();
        press(16'h0000);
        start_round(16'h5678);
        for (int k = 0; k < MT; k++) guess(16'h1234, 3'd0, 3'd0);
        chk("loss_state", 96'(state), 96'(5));
        chk("loss_bar", 96'(try_bar), 96'(18'h3FFFF));
        chk("loss_win", 96'(win), 96'(0));
        step(1'b1, 16'h1234);
        chk("loss_wins", 96'({wins0, wins1, round}), 96'({4'd1, 4'd0, 4'd1}));

        // Scoring timeout, then reset while a request is pending
        do_reset();
        press(16'h0000);
        start_round(16'h1234);
        step(1'b0, 16'h5678);
        for (int k = 1; k <= AT; k++) begin
            step(1'b1, 16'h9876);
            chk($sformatf("tmo_frozen%0d", k), 96'({sc_secret, sc_guess}), 96'({16'h1234, 16'h5678}));
            if (k == AT - 1)
                chk("tmo_pending", 96'({state, sc_req, err}), 96'({3'd4, 1'b1, 1'b0}));
        end
        chk("tmo_abort", 96'({state, sc_req, err, try_bar}), 96'({3'd3, 1'b0, 1'b1, 18'h0}));
        step(1'b0, 16'h2345);
        step(1'b1, 16'h2345);
        chk("rescore_req", 96'({state, sc_req, err}), 96'({3'd4, 1'b1, 1'b1}));
        do_reset();

        // Full match: setter alternates, OVER reached, press returns to IDLE
        press(16'h0000);
        for (int r = 0; r < RN; r++) begin
            chk($sformatf("match_setter%0d", r), 96'({state, setter}), 96'({3'd1, 1'(r)}));
            start_round(16'h1234);
            guess(16'h1234, 3'd4, 3'd0);
            step(1'b1, 16'h0000);
            press(16'h0000);
        end
        chk("match_over", 96'({state, round, wins0, wins1}), 96'({3'd6, 4'd4, 4'd2, 4'd2}));
        step(1'b0, 16'h0000);
        chk("match_idle", 96'({state, round, wins0, wins1, setter}),
            96'({3'd0, 4'd0, 4'd0, 4'd0, 1'b0}));

`ifdef BC_TURN_TIMEOUT_EN
        // Idling in GUESS forfeits the try
        do_reset();
        press(16'h0000);
        press(16'h1234);
        step(1'b0, 16'h0000);
        for (int k = 1; k <= TT; k++) begin
            step(1'b1, 16'h0000);
            if (k < TT) chk($sformatf("turn_wait%0d", k), 96'(tmo), 96'(0));
        end
        chk("turn_forfeit", 96'({tmo, try_bar, state}), 96'({1'b1, 18'h1, 3'd3}));
`else
        chk("tmo_tied", 96'(tmo), 96'(0));
`endif

        // Randomized play against the model
        do_reset();
        kn_cur = 1'b1;
        for (int n = 0; n < 4000; n++) begin
            int r;
            if ($urandom_range(2) == 0) kn_cur = ~kn_cur;
            r = int'($urandom_range(7));
            if (r < 2)      sw_r = 16'h0000;
            else if (r < 5) sw_r = rand_valid();
            else if (r == 5) sw_r = 16'h1234;
            else            sw_r = 16'($urandom);
            step(kn_cur, sw_r, ($urandom_range(9) == 0), 3'($urandom_range(4)), 3'($urandom_range(4)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
